// File: rtl/fp_sp_pkg.sv
// Shared definitions for the single-precision FP datapath (divider and multiplier).
// Holds the field widths, the exponent bias, the canonical quiet NaN, the divider FSM
// state type and the operand class type produced by fp_sp_classify.
package fp_sp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Divider working widths: mantissa with hidden bit, quotient, remainder.
    localparam int SIG_W = MAN_W + 1;   // 24
    localparam int QUO_W = MAN_W + 2;   // 25
    localparam int REM_W = MAN_W + 3;   // 26

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

endpackage

// File: rtl/fp_sp_classify.sv
// Combinational operand classifier for single-precision values.
// Ports:
//   x    in   32  IEEE 754 single-precision operand
//   sign out  1   sign bit of x
//   cls  out  2   class: zero (denormals flushed), normal, infinity, NaN
module fp_sp_classify
    import fp_sp_pkg::*;
(
    input  logic [31:0] x,
    output logic        sign,
    output fp_class_t   cls
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] frac_f;

    assign sign   = x[31];
    assign exp_f  = x[30:23];
    assign frac_f = x[22:0];

    always_comb begin
        if (exp_f == '0) begin
            cls = CLS_ZERO;
        end else if (exp_f == '1) begin
            cls = (frac_f == '0) ? CLS_INF : CLS_NAN;
        end else begin
            cls = CLS_NORM;
        end
    end

endmodule

// File: rtl/floating_point_spdiv.sv
// IEEE 754 single-precision divider, y = a / b, truncating (round toward zero).
// Restoring division, one quotient bit per clock; special operands bypass the loop.
// Ports:
//   clk     in   1   clock, rising edge
//   rst_n   in   1   synchronous reset, active low
//   y       out  32  quotient, held until the next result
//   u_flow  out  1   underflow flag, valid with done
//   o_flow  out  1   overflow / divide-by-zero flag, valid with done
//   busy    out  1   operation in progress
//   done    out  1   one-cycle result pulse
//   a       in   32  dividend, sampled when start is accepted
//   b       in   32  divisor, sampled when start is accepted
//   start   in   1   request, accepted only in IDLE
module floating_point_spdiv
    import fp_sp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] y,
    output logic        u_flow,
    output logic        o_flow,
    output logic        busy,
    output logic        done,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start
);

    state_t state, state_next;

    // Operand classification
    fp_class_t cls_a, cls_b;
    logic      sign_a, sign_b;

    fp_sp_classify u_cls_a (.x(a), .sign(sign_a), .cls(cls_a));
    fp_sp_classify u_cls_b (.x(b), .sign(sign_b), .cls(cls_b));

    logic        sign_in;
    logic        is_special;
    logic [31:0] spec_y_in;
    logic        spec_o_in;

    assign sign_in    = sign_a ^ sign_b;
    assign is_special = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);

    // Special-case result, priority ordered; 0/0 and inf/inf fall in the NaN bucket.
    always_comb begin
        spec_y_in = {sign_in, 31'b0};
        spec_o_in = 1'b0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
            spec_y_in = QNAN;
        end else if (cls_a != CLS_INF && cls_b == CLS_ZERO) begin
            spec_y_in = {sign_in, 8'hFF, 23'b0};
            spec_o_in = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_y_in = {sign_in, 8'hFF, 23'b0};
        end else begin
            spec_y_in = {sign_in, 31'b0};
        end
    end

    // Latched operation context
    logic             sign_r;
    logic [EXP_W-1:0] ea, eb;
    logic [SIG_W-1:0] mb;
    logic [REM_W-1:0] rem;
    logic [QUO_W-1:0] q;
    logic [4:0]       cnt;
    logic             special;
    logic [31:0]      spec_y;
    logic             spec_o;

    // One restoring step
    logic [REM_W-1:0] mb_ext;
    logic             rem_ge;
    logic [REM_W-1:0] rem_sub;
    logic [REM_W-1:0] rem_next;
    logic [QUO_W-1:0] q_next;

    assign mb_ext   = {2'b00, mb};
    assign rem_ge   = (rem >= mb_ext);
    assign rem_sub  = rem_ge ? (rem - mb_ext) : rem;
    assign rem_next = {rem_sub[REM_W-2:0], 1'b0};
    assign q_next   = {q[QUO_W-2:0], rem_ge};

    // Normaliser: the mantissa ratio lies in (0.5, 2), so at most one left shift.
    logic signed [9:0] exp_raw;
    logic signed [9:0] exp_adj;
    logic [MAN_W-1:0]  frac_n;
    logic [31:0]       norm_y;
    logic              norm_u;
    logic              norm_o;

    always_comb begin
        exp_raw = 10'($signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS);
        if (q[QUO_W-1]) begin
            exp_adj = exp_raw;
            frac_n  = q[MAN_W:1];
        end else begin
            exp_adj = exp_raw - 10'sd1;
            frac_n  = q[MAN_W-1:0];
        end
        norm_u = 1'b0;
        norm_o = 1'b0;
        if (exp_adj >= EXP_MAX) begin
            norm_y = {sign_r, 8'hFF, 23'b0};
            norm_o = 1'b1;
        end else if (exp_adj <= 0) begin
            norm_y = {sign_r, 31'b0};
            norm_u = 1'b1;
        end else begin
            norm_y = {sign_r, exp_adj[7:0], frac_n};
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = is_special ? ST_NORM : ST_DIV;
            ST_DIV:  if (cnt == '0) state_next = ST_NORM;
            ST_NORM: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r  <= 1'b0;
            ea      <= '0;
            eb      <= '0;
            mb      <= '0;
            rem     <= '0;
            q       <= '0;
            cnt     <= '0;
            special <= 1'b0;
            spec_y  <= '0;
            spec_o  <= 1'b0;
            y       <= '0;
            u_flow  <= 1'b0;
            o_flow  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign_r  <= sign_in;
                        ea      <= a[30:23];
                        eb      <= b[30:23];
                        mb      <= {1'b1, b[22:0]};
                        rem     <= {2'b00, 1'b1, a[22:0]};
                        q       <= '0;
                        cnt     <= 5'(QUO_W - 1);
                        special <= is_special;
                        spec_y  <= spec_y_in;
                        spec_o  <= spec_o_in;
                        busy    <= 1'b1;
                    end
                end
                ST_DIV: begin
                    rem <= rem_next;
                    q   <= q_next;
                    if (cnt != '0) cnt <= cnt - 5'd1;
                end
                ST_NORM: begin
                    if (special) begin
                        y      <= spec_y;
                        u_flow <= 1'b0;
                        o_flow <= spec_o;
                    end else begin
                        y      <= norm_y;
                        u_flow <= norm_u;
                        o_flow <= norm_o;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_spdiv.sv
// Self-checking bench for floating_point_spdiv: directed cases plus randomized
// operands compared against an arithmetic reference model of truncated FP division.
module tb_floating_point_spdiv;

    logic        clk;
    logic        rst_n;
    logic [31:0] y;
    logic        u_flow;
    logic        o_flow;
    logic        busy;
    logic        done;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;

    int n_tests = 0;
    int n_fail  = 0;

    floating_point_spdiv dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .y      (y),
        .u_flow (u_flow),
        .o_flow (o_flow),
        .busy   (busy),
        .done   (done),
        .a      (a),
        .b      (b),
        .start  (start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: classify by fields, quotient = floor(ma * 2^24 / mb).
    task automatic model(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] ye, output logic ue, output logic oe,
                         output int lat);
        int          ea, eb, e;
        logic        az, ai, an, bz, bi, bn, s;
        logic [63:0] ma, mb, qq;
        logic [22:0] fr;
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        az = (ea == 0);
        ai = (ea == 255) && (av[22:0] == 0);
        an = (ea == 255) && (av[22:0] != 0);
        bz = (eb == 0);
        bi = (eb == 255) && (bv[22:0] == 0);
        bn = (eb == 255) && (bv[22:0] != 0);
        s  = av[31] ^ bv[31];
        ue = 1'b0;
        oe = 1'b0;
        lat = 1;
        if (an || bn || (az && bz) || (ai && bi)) begin
            ye = 32'h7FC00000;
        end else if (!ai && bz) begin
            ye = {s, 8'hFF, 23'h0};
            oe = 1'b1;
        end else if (ai) begin
            ye = {s, 8'hFF, 23'h0};
        end else if (bi || az) begin
            ye = {s, 31'h0};
        end else begin
            lat = 26;
            ma = {40'h0, 1'b1, av[22:0]};
            mb = {40'h0, 1'b1, bv[22:0]};
            qq = (ma << 24) / mb;
            e  = ea - eb + 127;
            if (qq >= 64'd16777216) begin
                fr = 23'(qq >> 1);
            end else begin
                fr = 23'(qq);
                e  = e - 1;
            end
            if (e >= 255) begin
                ye = {s, 8'hFF, 23'h0};
                oe = 1'b1;
            end else if (e <= 0) begin
                ye = {s, 31'h0};
                ue = 1'b1;
            end else begin
                ye = {s, 8'(e), fr};
            end
        end
    endtask

    // Issue one operation; optionally pulse start again poke_at cycles after acceptance.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int poke_at);
        logic [31:0] ye;
        logic        ue, oe;
        int          lat_exp, lat, bad;
        model(av, bv, ye, ue, oe, lat_exp);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_set", {31'b0, busy}, 32'd1);
        check("done_fall", {31'b0, done}, 32'd0);
        lat = 0;
        bad = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) bad++;
            if (lat == poke_at) begin
                a = $urandom;
                b = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(lat_exp));
        check("busy_hold", 32'(bad), 32'd0);
        check("busy_clr", {31'b0, busy}, 32'd0);
        check("y", y, ye);
        check("u_flow", {31'b0, u_flow}, {31'b0, ue});
        check("o_flow", {31'b0, o_flow}, {31'b0, oe});
    endtask

    function automatic logic [31:0] rand_op();
        int          m;
        logic [31:0] r;
        m = $urandom_range(0, 9);
        r = $urandom;
        case (m)
            0:       r[30:23] = 8'h00;
            1:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2:       begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            3, 4:    r[30:23] = 8'($urandom_range(1, 254));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, 32'h0);
        check("rst_u", {31'b0, u_flow}, 32'd0);
        check("rst_o", {31'b0, o_flow}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        // Basic quotient, then done must be a single-cycle pulse.
        do_op(32'h40C00000, 32'h40000000, -1);
        check("t1_y", y, 32'h40400000);
        @(posedge clk);
        #1;
        check("done_pulse", {31'b0, done}, 32'd0);

        // Truncation, then a back-to-back start on the cycle after done.
        do_op(32'h3F800000, 32'h40400000, -1);
        check("t2_y", y, 32'h3EAAAAAA);
        do_op(32'hC0C00000, 32'h40000000, -1);
        check("t2b_y", y, 32'hC0400000);

        // Divide by zero and 0/0.
        do_op(32'h40000000, 32'h00000000, -1);
        check("t3_y", y, 32'h7F800000);
        do_op(32'h00000000, 32'h00000000, -1);
        check("t3b_y", y, 32'h7FC00000);

        // Range limits.
        do_op(32'h7F000000, 32'h00800000, -1);
        check("t4_y", y, 32'h7F800000);
        check("t4_o", {31'b0, o_flow}, 32'd1);
        do_op(32'h00800000, 32'h7F000000, -1);
        check("t4b_y", y, 32'h00000000);
        check("t4b_u", {31'b0, u_flow}, 32'd1);

        // Reset mid-division.
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_y", y, 32'h0);
        check("mrst_u", {31'b0, u_flow}, 32'd0);
        check("mrst_o", {31'b0, o_flow}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("mrst_idle", {30'b0, busy, done}, 32'd0);
        do_op(32'h3F800000, 32'h3F800000, -1);
        check("t5_y", y, 32'h3F800000);

        // start pulsed while busy must be ignored.
        do_op(32'h40C00000, 32'h40000000, 5);
        check("t6_y", y, 32'h40400000);

        for (int i = 0; i < 200; i++) begin
            do_op(rand_op(), rand_op(),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
